mem_stage: RTL and testbench

Memory stage of the 5-stage ARM pipeline. It sits between the EXE/MEM pipeline register and the MEM/WB register.
- Consumes the registered ALU result (address), Val_Rm (store data) and control bits.
- Performs LDR/STR against an external 16-bit asynchronous SRAM as two half-word accesses.
- Deasserts ready to freeze the pipeline until the 32-bit access completes; all other fields pass through to MEM/WB.

---
 rtl/mem_stage_pkg.sv | 18 +
 rtl/mem_stage_if.sv | 38 +++
 rtl/mem_stage_sram_ctrl.sv | 126 ++++++++++++
 rtl/mem_stage.sv | 78 +++++++
 tb/tb_mem_stage.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the ARM pipeline memory stage.
package mem_stage_pkg;

    // Byte address that maps onto SRAM word 0.
    localparam logic [31:0] DefaultBaseAddr = 32'd1024;

    // Data width of the external asynchronous SRAM.
    localparam int unsigned SramDw = 16;

    // Access sequencer states: two half-word phases then a one-cycle release.
    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StHigh,
        StDone
    } state_e;

endpackage

// File: rtl/mem_stage_if.sv
// External 16-bit asynchronous SRAM bus driven by the memory stage.
interface mem_stage_if
    import mem_stage_pkg::*;
#(
    parameter int unsigned SRAM_AW = 18
);

    logic [SRAM_AW-1:0] sram_addr;
    logic [SramDw-1:0]  sram_dq_out;
    logic               sram_dq_oe;
    logic [SramDw-1:0]  sram_dq_in;
    logic               sram_we_n;
    logic               sram_oe_n;
    logic               sram_ce_n;

    // Controller side.
    modport master (
        output sram_addr,
        output sram_dq_out,
        output sram_dq_oe,
        output sram_we_n,
        output sram_oe_n,
        output sram_ce_n,
        input  sram_dq_in
    );

    // SRAM / pad side.
    modport slave (
        input  sram_addr,
        input  sram_dq_out,
        input  sram_dq_oe,
        input  sram_we_n,
        input  sram_oe_n,
        input  sram_ce_n,
        output sram_dq_in
    );

endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// SRAM access sequencer: splits a 32-bit load/store into two half-word
// phases of WAIT_CYCLES each, drives the SRAM pins and assembles load data.
module mem_stage_sram_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [SRAM_AW-2:0] widx,
    input  logic [31:0]        wdata,
    output logic               ready,
    output logic [31:0]        rd_data,
    mem_stage_if.master        sram
);

    localparam int unsigned    CntW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [SRAM_AW-2:0] widx_q, widx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               is_wr_q, is_wr_d;
    logic [31:0]        rd_data_q, rd_data_d;

    logic req;
    logic last;

    assign req     = rd_en | wr_en;
    assign last    = (cnt_q == CntLast);
    assign rd_data = rd_data_q;

    // Next-state, phase counter, request latch and load-data capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        widx_d    = widx_q;
        wdata_d   = wdata_q;
        is_wr_d   = is_wr_q;
        rd_data_d = rd_data_q;
        ready     = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = ~req;
                if (req) begin
                    state_d = StLow;
                    cnt_d   = '0;
                    widx_d  = widx;
                    wdata_d = wdata;
                    // A simultaneous load and store resolves to a load.
                    is_wr_d = wr_en & ~rd_en;
                end
            end
            StLow: begin
                if (last) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                    if (!is_wr_q) rd_data_d[15:0] = sram.sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHigh: begin
                if (last) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    if (!is_wr_q) rd_data_d[31:16] = sram.sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                // The pipeline advances on this edge, so never re-issue.
                ready   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Pin drive decoded from the current phase; everything idle outside LOW/HIGH.
    always_comb begin
        sram.sram_addr   = '0;
        sram.sram_dq_out = '0;
        sram.sram_dq_oe  = 1'b0;
        sram.sram_we_n   = 1'b1;
        sram.sram_oe_n   = 1'b1;
        sram.sram_ce_n   = 1'b1;
        if (state_q == StLow || state_q == StHigh) begin
            sram.sram_ce_n = 1'b0;
            sram.sram_addr = {widx_q, (state_q == StHigh)};
            if (is_wr_q) begin
                sram.sram_dq_oe  = 1'b1;
                sram.sram_dq_out = (state_q == StHigh) ? wdata_q[31:16] : wdata_q[15:0];
                // Release WE one cycle early for data hold, unless the phase is one cycle.
                sram.sram_we_n   = ~((WAIT_CYCLES == 1) || !last);
            end else begin
                sram.sram_oe_n = 1'b0;
            end
        end
    end

    // State registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            widx_q    <= '0;
            wdata_q   <= '0;
            is_wr_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            widx_q    <= widx_d;
            wdata_q   <= wdata_d;
            is_wr_q   <= is_wr_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage ARM pipeline: maps the ALU address onto the
// 16-bit SRAM, stalls via ready during the access, passes other fields on.
// Optional macro MEM_STALL_CNT_EN adds a saturating stall_cycles counter.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DefaultBaseAddr,
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_en_in,
    input  logic        MEM_R_EN_in,
    input  logic        MEM_W_EN_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] Val_Rm_in,
    input  logic [3:0]  Dest_in,
    output logic        WB_en,
    output logic        MEM_R_EN,
    output logic [31:0] ALU_result,
    output logic [31:0] Mem_read_value,
    output logic [3:0]  Dest,
    output logic        ready,
`ifdef MEM_STALL_CNT_EN
    output logic [31:0] stall_cycles,
`endif
    mem_stage_if.master sram
);

    logic [31:0]        off;
    logic [SRAM_AW-2:0] widx;
    logic               unused_off;

    assign WB_en      = WB_en_in;
    assign MEM_R_EN   = MEM_R_EN_in;
    assign ALU_result = ALU_result_in;
    assign Dest       = Dest_in;

    // Unaligned low bits and anything above the SRAM range are dropped.
    assign off        = ALU_result_in - BASE_ADDR;
    assign widx       = off[SRAM_AW:2];
    assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};

    mem_stage_sram_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .SRAM_AW     (SRAM_AW)
    ) u_sram_ctrl (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (MEM_R_EN_in),
        .wr_en   (MEM_W_EN_in),
        .widx    (widx),
        .wdata   (Val_Rm_in),
        .ready   (ready),
        .rd_data (Mem_read_value),
        .sram    (sram)
    );

`ifdef MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count frozen cycles, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ready && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a behavioural SRAM model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_en_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [31:0] ALU_result_in, Val_Rm_in;
    logic [3:0]  Dest_in;
    logic        WB_en, MEM_R_EN, ready;
    logic [31:0] ALU_result, Mem_read_value;
    logic [3:0]  Dest;
`ifdef MEM_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] mem [0:63];

    mem_stage_if #(.SRAM_AW(18)) sram_if ();

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .WB_en_in       (WB_en_in),
        .MEM_R_EN_in    (MEM_R_EN_in),
        .MEM_W_EN_in    (MEM_W_EN_in),
        .ALU_result_in  (ALU_result_in),
        .Val_Rm_in      (Val_Rm_in),
        .Dest_in        (Dest_in),
        .WB_en          (WB_en),
        .MEM_R_EN       (MEM_R_EN),
        .ALU_result     (ALU_result),
        .Mem_read_value (Mem_read_value),
        .Dest           (Dest),
        .ready          (ready),
`ifdef MEM_STALL_CNT_EN
        .stall_cycles   (stall_cycles),
`endif
        .sram           (sram_if)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM model: read when CE/OE low, write while CE/WE low.
    assign sram_if.sram_dq_in = (!sram_if.sram_ce_n && !sram_if.sram_oe_n) ?
                                mem[sram_if.sram_addr[5:0]] : 16'hxxxx;

    always @(negedge clk) begin
        if (!sram_if.sram_ce_n && !sram_if.sram_we_n && sram_if.sram_dq_oe)
            mem[sram_if.sram_addr[5:0]] = sram_if.sram_dq_out;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        WB_en_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
        ALU_result_in = 32'd0; Val_Rm_in = 32'd0; Dest_in = 4'd0;
    endtask

    // Issue one memory instruction and hold it until ready; called just after a posedge.
    task automatic mem_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] val, output int stall, output int we_cnt,
                          output logic [17:0] a_lo, output logic [17:0] a_hi,
                          output logic [31:0] rdv, output logic timed_out);
        logic seen;
        MEM_R_EN_in = rd; MEM_W_EN_in = wr; ALU_result_in = addr; Val_Rm_in = val;
        WB_en_in = rd; Dest_in = 4'd3;
        stall = 0; we_cnt = 0; a_lo = '0; a_hi = '0; rdv = '0; timed_out = 1'b1; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!sram_if.sram_ce_n) begin
                if (!seen) a_lo = sram_if.sram_addr;
                seen = 1'b1;
                a_hi = sram_if.sram_addr;
            end
            if (!sram_if.sram_we_n) we_cnt++;
            if (ready) begin
                rdv = Mem_read_value;
                timed_out = 1'b0;
                break;
            end
            stall++;
        end
        step();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_cmp++; if ({sram_if.sram_we_n, sram_if.sram_oe_n, sram_if.sram_ce_n, sram_if.sram_dq_oe} !== 4'b1110) begin
            n_err++; $display("FAIL reset_strobes: got we/oe/ce/dqoe=%b%b%b%b want 1110", sram_if.sram_we_n,
                              sram_if.sram_oe_n, sram_if.sram_ce_n, sram_if.sram_dq_oe);
        end
        n_cmp++; if (sram_if.sram_addr !== 18'd0 || sram_if.sram_dq_out !== 16'd0) begin
            n_err++; $display("FAIL reset_bus: got addr=%h dq=%h want 0/0", sram_if.sram_addr, sram_if.sram_dq_out);
        end
        n_cmp++; if (Mem_read_value !== 32'd0) begin n_err++; $display("FAIL reset_rdval: got %h want 0", Mem_read_value); end
        step();
    endtask

    task automatic test_passthrough();
        WB_en_in = 1'b1; MEM_R_EN_in = 1'b1; ALU_result_in = 32'hCAFE_0123; Dest_in = 4'hA;
        #1;
        n_cmp++; if ({WB_en, MEM_R_EN, Dest, ALU_result} !== {1'b1, 1'b1, 4'hA, 32'hCAFE_0123}) begin
            n_err++; $display("FAIL passthru: got %b %b %h %h want 1 1 a cafe0123", WB_en, MEM_R_EN, Dest, ALU_result);
        end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL req_ready_comb: got %b want 0", ready); end
        clear_inputs();
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL idle_ready_comb: got %b want 1", ready); end
        step();
    endtask

    task automatic test_reset_mid_write();
        mem[5] = 16'hA5A5;
        MEM_W_EN_in = 1'b1; ALU_result_in = 32'd1032; Val_Rm_in = 32'h1234_5678;
        step();
        n_cmp++; if ({ready, sram_if.sram_we_n} !== 2'b00) begin
            n_err++; $display("FAIL midwr_low_phase: got ready=%b we_n=%b want 0 0", ready, sram_if.sram_we_n);
        end
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({ready, sram_if.sram_we_n, sram_if.sram_oe_n, sram_if.sram_ce_n, sram_if.sram_dq_oe} !== 5'b11110) begin
            n_err++; $display("FAIL midwr_after_rst: got ready/we/oe/ce/dqoe=%b%b%b%b%b want 11110", ready,
                              sram_if.sram_we_n, sram_if.sram_oe_n, sram_if.sram_ce_n, sram_if.sram_dq_oe);
        end
        n_cmp++; if (mem[5] !== 16'hA5A5) begin n_err++; $display("FAIL midwr_high_half: got %h want a5a5", mem[5]); end
        step();
    endtask

    task automatic test_store();
        int stall, we_cnt; logic [17:0] a_lo, a_hi; logic [31:0] rdv; logic to;
        mem[0] = 16'h0; mem[1] = 16'h0;
        mem_op(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, stall, we_cnt, a_lo, a_hi, rdv, to);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL str_timeout: got timeout=%b want 0", to); end
        n_cmp++; if (stall !== 7) begin n_err++; $display("FAIL str_stall: got %0d want 7", stall); end
        n_cmp++; if ({mem[1], mem[0]} !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL str_data: got %h%h want deadbeef", mem[1], mem[0]);
        end
        n_cmp++; if (we_cnt !== 4) begin n_err++; $display("FAIL str_we_cycles: got %0d want 4", we_cnt); end
        n_cmp++; if ({a_lo, a_hi} !== {18'd0, 18'd1}) begin
            n_err++; $display("FAIL str_addr: got %0d,%0d want 0,1", a_lo, a_hi);
        end
    endtask

    task automatic test_load();
        int stall, we_cnt; logic [17:0] a_lo, a_hi; logic [31:0] rdv; logic to;
        mem_op(1'b1, 1'b0, 32'd1024, 32'd0, stall, we_cnt, a_lo, a_hi, rdv, to);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL ldr_timeout: got timeout=%b want 0", to); end
        n_cmp++; if (rdv !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ldr_data: got %h want deadbeef", rdv); end
        n_cmp++; if (stall !== 7) begin n_err++; $display("FAIL ldr_stall: got %0d want 7", stall); end
        n_cmp++; if (we_cnt !== 0) begin n_err++; $display("FAIL ldr_we: got %0d want 0", we_cnt); end
    endtask

    task automatic test_write_hold();
        int stall, we_cnt; logic [17:0] a_lo, a_hi; logic [31:0] rdv; logic to;
        mem_op(1'b0, 1'b1, 32'd1040, 32'h0102_0304, stall, we_cnt, a_lo, a_hi, rdv, to);
        n_cmp++; if (Mem_read_value !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL hold_rdval: got %h want deadbeef", Mem_read_value);
        end
        n_cmp++; if ({mem[9], mem[8]} !== 32'h0102_0304) begin
            n_err++; $display("FAIL hold_store: got %h%h want 01020304", mem[9], mem[8]);
        end
    endtask

    task automatic test_back_to_back();
        int stall, we_cnt; logic [17:0] a_lo, a_hi; logic [31:0] rdv; logic to;
        mem[4] = 16'h4444; mem[5] = 16'h5555;
        WB_en_in = 1'b1; ALU_result_in = 32'd7; Dest_in = 4'd2;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_add_ready: got %b want 1", ready); end
        step();
        mem_op(1'b1, 1'b0, 32'd1032, 32'd0, stall, we_cnt, a_lo, a_hi, rdv, to);
        n_cmp++; if ({a_lo, a_hi} !== {18'd4, 18'd5}) begin
            n_err++; $display("FAIL b2b_addr: got %0d,%0d want 4,5", a_lo, a_hi);
        end
        n_cmp++; if (rdv !== 32'h5555_4444) begin n_err++; $display("FAIL b2b_data: got %h want 55554444", rdv); end
        n_cmp++; if (stall !== 7 || to !== 1'b0) begin
            n_err++; $display("FAIL b2b_stall: got %0d timeout=%b want 7 0", stall, to);
        end
    endtask

    task automatic test_both_enabled();
        int stall, we_cnt; logic [17:0] a_lo, a_hi; logic [31:0] rdv; logic to;
        mem[2] = 16'h2222; mem[3] = 16'h3333;
        mem_op(1'b1, 1'b1, 32'd1028, 32'hFFFF_0000, stall, we_cnt, a_lo, a_hi, rdv, to);
        n_cmp++; if (we_cnt !== 0) begin n_err++; $display("FAIL both_we: got %0d low cycles want 0", we_cnt); end
        n_cmp++; if (rdv !== 32'h3333_2222) begin n_err++; $display("FAIL both_data: got %h want 33332222", rdv); end
        n_cmp++; if ({mem[3], mem[2]} !== 32'h3333_2222) begin
            n_err++; $display("FAIL both_sram: got %h%h want 33332222", mem[3], mem[2]);
        end
    endtask

`ifdef MEM_STALL_CNT_EN
    task automatic test_stall_cnt();
        int stall, we_cnt; logic [17:0] a_lo, a_hi; logic [31:0] rdv; logic to;
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL stallcnt_rst: got %0d want 0", stall_cycles); end
        mem_op(1'b1, 1'b0, 32'd1024, 32'd0, stall, we_cnt, a_lo, a_hi, rdv, to);
        mem_op(1'b1, 1'b0, 32'd1028, 32'd0, stall, we_cnt, a_lo, a_hi, rdv, to);
        n_cmp++; if (stall_cycles !== 32'd14) begin n_err++; $display("FAIL stallcnt_two_ldr: got %0d want 14", stall_cycles); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_passthrough();
        test_reset_mid_write();
        test_store();
        test_load();
        test_write_hold();
        test_back_to_back();
        test_both_enabled();
`ifdef MEM_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
